// File: rtl/crc_share_sched.sv
// Round-robin scheduler sharing one serial CRC LFSR among NREQ requesters.
// A granted word is shifted MSB-first, then its CRC is offered with the requester ID.
module crc_share_sched #(
    parameter int unsigned             NREQ  = 4,
    parameter int unsigned             MSG_W = 6,
    parameter int unsigned             CRC_W = 5,
    parameter logic [CRC_W-1:0]        POLY  = 5'b01011,
    parameter logic [CRC_W-1:0]        INIT  = 5'b00000,
    parameter int unsigned             ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*MSG_W-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    res_valid,
    output logic [CRC_W-1:0]        res_crc,
    output logic [ID_W-1:0]         res_id,
    input  logic                    res_ready,
    output logic                    busy
);

    localparam int unsigned CNT_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        RESULT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [ID_W-1:0]      last;
    logic [MSG_W-1:0]     sreg;
    logic [CRC_W-1:0]     crc;
    logic [CRC_W-1:0]     crc_next;
    logic [CNT_W-1:0]     cnt;
    logic                 last_bit;
    logic                 any_valid;
    logic [ID_W-1:0]      grant_idx;
    logic                 accept;
    logic                 feedback;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        int unsigned idx;
        logic        found;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
        any_valid = found;
    end

    assign accept   = (state == IDLE) && any_valid;
    assign last_bit = (cnt == CNT_W'(MSG_W - 1));

    always_comb begin
        feedback = sreg[MSG_W-1] ^ crc[CRC_W-1];
        crc_next = {crc[CRC_W-2:0], 1'b0} ^ (feedback ? POLY : '0);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_valid) state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = RESULT;
            RESULT:  if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid) req_ready[grant_idx] = 1'b1;
            end
            SHIFT, RESULT: busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last      <= ID_W'(NREQ - 1);
            sreg      <= '0;
            crc       <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_crc   <= '0;
            res_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg   <= req_data[grant_idx*MSG_W +: MSG_W];
                        crc    <= INIT;
                        cnt    <= '0;
                        res_id <= grant_idx;
                        last   <= grant_idx;
                    end
                end
                SHIFT: begin
                    crc  <= crc_next;
                    sreg <= sreg << 1;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        res_crc   <= crc_next;
                        res_valid <= 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: res_valid <= 1'b0;
            endcase
        end
    end

endmodule
